mod_det_loader: RTL and testbench

MOD_DET_LOADER -- requirements
Module: mod_det_loader

---
 rtl/mod_det_loader_pkg.sv | 19 +
 rtl/mod_det_loader_if.sv | 23 ++
 rtl/mod_det_loader_det_timeout_cnt.sv | 28 ++
 rtl/mod_det_loader.sv | 129 ++++++++++++
 tb/tb_mod_det_loader.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mod_det_loader_pkg.sv
// Shared types and sizes for the determinant loader and its timeout counter.
// The default timeout budget lives here so that every user agrees on it.
package mod_det_pkg;
    localparam int ELEM_W             = 8;
    localparam int RES_W              = 16;
    localparam int N_ELEM             = 16;
    localparam int IDX_W              = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        OUT
    } state_e;

    typedef logic [ELEM_W-1:0] elem_t;
    typedef logic [RES_W-1:0]  res_t;
endpackage

// File: rtl/mod_det_loader_if.sv
// Element-in and result-out handshakes of the loader.
// The master side is the producer/consumer; the slave side is the loader.
interface mod_det_loader_if;
    import mod_det_pkg::*;

    elem_t in_data;
    logic  in_valid;
    logic  in_ready;
    res_t  res_data;
    logic  res_valid;
    logic  res_ready;
    logic  err;

    modport master (
        output in_data, in_valid, res_ready,
        input  in_ready, res_data, res_valid, err
    );

    modport slave (
        input  in_data, in_valid, res_ready,
        output in_ready, res_data, res_valid, err
    );
endinterface

// File: rtl/mod_det_loader_det_timeout_cnt.sv
// Counts consecutive WAIT cycles; expired is high in the LIMIT-th one.
// Zero latency on expired; the count drops to zero whenever run is low.
module det_timeout_cnt #(
    parameter int LIMIT = mod_det_pkg::DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = run ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == CW'(LIMIT - 1));
endmodule

// File: rtl/mod_det_loader.sv
// Loads 16 elements a..p, pulses start, waits for done and presents the result.
// Optional WAIT timeout is built when DET_TIMEOUT_EN is defined.
module mod_det_loader
    import mod_det_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    mod_det_loader_if.slave   bus,
    output elem_t             a, b, c, d, e, f, g, h,
    output elem_t             i, j, k, l, m, n, o, p,
    output logic              start,
    input  logic              done,
    input  res_t              resultado
);
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    elem_t              elem_q [N_ELEM];
    elem_t              elem_d [N_ELEM];
    res_t               res_q, res_d;
    logic               err_q, err_d;
    logic               start_q, start_d;
    logic               rv_q, rv_d;
    logic               expired;

`ifdef DET_TIMEOUT_EN
    det_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state_q == WAIT),
        .expired (expired)
    );
`else
    // No timeout hardware: WAIT holds until done or clear.
    assign expired = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        elem_d  = elem_q;
        res_d   = res_q;
        err_d   = err_q;
        rv_d    = rv_q;
        start_d = 1'b0;
        if (clear) begin
            state_d = LOAD;
            idx_d   = '0;
            rv_d    = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.in_valid) begin
                        elem_d[idx_q] = bus.in_data;
                        idx_d         = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(N_ELEM - 1)) begin
                            state_d = START;
                            start_d = 1'b1;
                        end
                    end
                end
                START: state_d = WAIT;
                WAIT: begin
                    // done wins over a timeout landing in the same cycle
                    if (done) begin
                        res_d   = resultado;
                        err_d   = 1'b0;
                        rv_d    = 1'b1;
                        state_d = OUT;
                    end else if (expired) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        rv_d    = 1'b1;
                        state_d = OUT;
                    end
                end
                OUT: begin
                    if (bus.res_ready) begin
                        rv_d    = 1'b0;
                        state_d = LOAD;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            idx_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
            start_q <= 1'b0;
            for (int x = 0; x < N_ELEM; x++) begin
                elem_q[x] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            err_q   <= err_d;
            rv_q    <= rv_d;
            start_q <= start_d;
            elem_q  <= elem_d;
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.res_data  = res_q;
    assign bus.res_valid = rv_q;
    assign bus.err       = err_q;
    assign start         = start_q;

    assign a = elem_q[0];   assign b = elem_q[1];
    assign c = elem_q[2];   assign d = elem_q[3];
    assign e = elem_q[4];   assign f = elem_q[5];
    assign g = elem_q[6];   assign h = elem_q[7];
    assign i = elem_q[8];   assign j = elem_q[9];
    assign k = elem_q[10];  assign l = elem_q[11];
    assign m = elem_q[12];  assign n = elem_q[13];
    assign o = elem_q[14];  assign p = elem_q[15];
endmodule

// File: tb/tb_mod_det_loader.sv
// Randomised bench for mod_det_loader against a transaction-level matrix/result model.
// Covers both DET_TIMEOUT_EN builds (timeout budget overridden to 20 cycles).
module tb_mod_det_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        done = 1'b0;
    logic [15:0] resultado = '0;
    logic        start;
    logic [7:0]  a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p;

    mod_det_loader_if bus ();

    mod_det_loader #(.TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .i(i), .j(j), .k(k), .l(l), .m(m), .n(n), .o(o), .p(p),
        .start(start), .done(done), .resultado(resultado)
    );

    always #5 clk = ~clk;

    wire [127:0] obs_mat = {a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p};

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  exp_elem [16];
    logic [7:0]  stim [16];
    logic [7:0]  dir_vals [16] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                                   8'd2, 8'd6, 8'd4, 8'd8, 8'd3, 8'd1, 8'd1, 8'd2};
    logic [15:0] exp_res;
    logic        exp_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vec_cnt++;
        if (obs !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [127:0] exp_pack();
        logic [127:0] r = '0;
        for (int x = 0; x < 16; x++) r = {r[119:0], exp_elem[x]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams stim[0..15] from index 0; returns in the start cycle.
    task automatic load16(input int max_gap);
        for (int x = 0; x < 16; x++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                bus.in_valid = 1'b0;
                tick();
                chk("in_ready_idle", bus.in_ready, 1'b1);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = stim[x];
            chk("in_ready_load", bus.in_ready, 1'b1);
            chk("start_low_load", start, 1'b0);
            tick();
            exp_elem[x] = stim[x];
        end
        bus.in_valid = 1'b0;
        chk("start_pulse", start, 1'b1);
        chk("in_ready_start", bus.in_ready, 1'b0);
        chk("matrix", obs_mat, exp_pack());
    endtask

    // Stub determinant: done raised 'delay' cycles after the start cycle.
    task automatic run_det(input int delay, input logic [15:0] res);
        repeat (delay) begin
            tick();
            chk("start_single", start, 1'b0);
            chk("no_early_res", bus.res_valid, 1'b0);
            chk("in_ready_wait", bus.in_ready, 1'b0);
        end
        done      = 1'b1;
        resultado = res;
        tick();
        done      = 1'b0;
        exp_res   = res;
        exp_err   = 1'b0;
        chk("res_valid_set", bus.res_valid, 1'b1);
        chk("res_data", bus.res_data, exp_res);
        chk("err_clear", bus.err, 1'b0);
        chk("matrix_hold", obs_mat, exp_pack());
    endtask

    // Holds res_ready low for 'hold' cycles (optionally ghost done), then accepts.
    task automatic drain(input int hold, input bit ghost);
        for (int x = 0; x < hold; x++) begin
            if (ghost && x == hold / 2) begin
                done      = 1'b1;
                resultado = ~exp_res;
            end
            tick();
            done = 1'b0;
            chk("res_valid_hold", bus.res_valid, 1'b1);
            chk("res_data_hold", bus.res_data, exp_res);
            chk("err_hold", bus.err, exp_err);
            chk("in_ready_out", bus.in_ready, 1'b0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("res_valid_drop", bus.res_valid, 1'b0);
        chk("in_ready_b2b", bus.in_ready, 1'b1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;
        for (int x = 0; x < 16; x++) exp_elem[x] = '0;

        #3;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_start", start, 1'b0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_res_data", bus.res_data, 16'h0);
        chk("rst_matrix", obs_mat, 128'h0);
        #4 rst_n = 1'b1;
        tick();

        // Directed matrix, immediate consume, then held consume with ghost done
        for (int x = 0; x < 16; x++) stim[x] = dir_vals[x];
        load16(0);
        run_det(5, 16'h00AB);
        drain(0, 1'b0);
        load16(0);
        run_det(5, 16'h00AB);
        drain(10, 1'b1);

        // done outside WAIT is ignored
        done = 1'b1; resultado = 16'hBEEF;
        tick();
        done = 1'b0;
        chk("done_in_load", bus.res_valid, 1'b0);
        chk("done_in_load_rdy", bus.in_ready, 1'b1);

        // clear after 7 accepts, colliding with an 8th
        for (int x = 0; x < 7; x++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            tick();
            exp_elem[x] = bus.in_data;
        end
        bus.in_data = 8'h5A;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clear_matrix", obs_mat, exp_pack());
        chk("clear_in_ready", bus.in_ready, 1'b1);
        for (int x = 0; x < 16; x++) stim[x] = 8'($urandom);
        load16(1);
        run_det(3, 16'($urandom));

        // clear beats res_ready in OUT
        clear = 1'b1; bus.res_ready = 1'b1;
        tick();
        clear = 1'b0; bus.res_ready = 1'b0;
        chk("clear_out_rv", bus.res_valid, 1'b0);
        chk("clear_out_rdy", bus.in_ready, 1'b1);

        for (int t = 0; t < 20; t++) begin
            for (int x = 0; x < 16; x++) stim[x] = 8'($urandom);
            load16(2);
            run_det(int'($urandom_range(12, 1)), 16'($urandom));
            drain(int'($urandom_range(4, 0)), 1'($urandom));
        end

        // Stub never answers
        for (int x = 0; x < 16; x++) stim[x] = 8'($urandom);
        load16(0);
`ifdef DET_TIMEOUT_EN
        repeat (20) begin
            tick();
            chk("to_pending", bus.res_valid, 1'b0);
        end
        tick();
        chk("to_res_valid", bus.res_valid, 1'b1);
        chk("to_err", bus.err, 1'b1);
        chk("to_res_data", bus.res_data, 16'h0);
        exp_res = '0;
        exp_err = 1'b1;
        drain(2, 1'b0);
`else
        repeat (300) begin
            tick();
            chk("no_to_res_valid", bus.res_valid, 1'b0);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("no_to_clear", bus.in_ready, 1'b1);
`endif

        // Asynchronous reset in WAIT
        for (int x = 0; x < 16; x++) stim[x] = 8'($urandom);
        load16(0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int x = 0; x < 16; x++) exp_elem[x] = '0;
        chk("arst_matrix", obs_mat, 128'h0);
        chk("arst_start", start, 1'b0);
        chk("arst_res_valid", bus.res_valid, 1'b0);
        chk("arst_err", bus.err, 1'b0);
        chk("arst_res_data", bus.res_data, 16'h0);
        #2 rst_n = 1'b1;
        repeat (20) begin
            tick();
            chk("post_rst_start", start, 1'b0);
            chk("post_rst_rv", bus.res_valid, 1'b0);
            chk("post_rst_rdy", bus.in_ready, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
